// File: rtl/ahb_sram_slave_if.sv
// -----------------------------------------------------------------------------
// ahb_sram_slave_if
// AHB-Lite slave-side bus bundle for ahb_sram_slave.
//
// Signals:
//   hsel       select from the address decoder
//   haddr      byte address
//   htrans     transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
//   hwrite     1 = write, 0 = read
//   hsize      0 = byte, 1 = halfword, 2 = word
//   hwdata     write data, valid in the data phase
//   hready     bus-level ready from the response multiplexer
//   hreadyout  slave ready towards the response multiplexer
//   hresp      0 = OKAY, 1 = ERROR
//   hrdata     read data towards the response multiplexer
//
// The master modport is the bus/fabric side (it also supplies hready).
// -----------------------------------------------------------------------------
interface ahb_sram_slave_if;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// -----------------------------------------------------------------------------
// ahb_sram_slave
// AHB-Lite SRAM slave: DEPTH x 32-bit word array with a programmable number of
// data-phase wait states, little-endian byte-lane writes and back-to-back
// transfer pipelining.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two)
//   WAIT_STATES  data-phase wait cycles, 0..7
//
// Ports:
//   hclk     sole clock, rising edge
//   hresetn  asynchronous active-low reset
//   bus      ahb_sram_slave_if.slave (address/control/data/response signals)
//
// Build option:
//   AHB_SRAM_ERR_EN  when defined, out-of-range addresses, addresses misaligned
//                    to hsize and hsize>2 get a two-cycle ERROR response with
//                    no array access. When undefined, hresp is tied to OKAY,
//                    addresses wrap modulo DEPTH, alignment is ignored and
//                    hsize>2 behaves as a word transfer.
// -----------------------------------------------------------------------------
module ahb_sram_slave #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic             hclk,
   input  logic             hresetn,
   ahb_sram_slave_if.slave  bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR1 = 2'd2;
   localparam logic [1:0] ST_ERR2 = 2'd3;

   // Counter value on the last wait cycle (never reached when WAIT_STATES=0).
   localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

   logic [1:0]    state_q;
   logic          dp_valid_q;   // a registered transfer is in its data phase
   logic [2:0]    wait_cnt_q;
   logic [AW-1:0] addr_q;
   logic [1:0]    offs_q;
   logic          write_q;
   logic [2:0]    size_q;
   logic [31:0]   hrdata_q;

   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic          addr_err;
   logic          complete;
   logic          wr_fire;
   logic          rd_fire;
   logic [3:0]    lanes;
   logic [31:0]   rd_word;
   logic          unused_bits;

   // A new address phase can only be taken while this slave shows ready.
   assign accept = ((state_q == ST_IDLE) || (state_q == ST_ERR2)) &&
                   bus.hsel && bus.hready && bus.htrans[1];

`ifdef AHB_SRAM_ERR_EN
   always_comb begin
      addr_err = (64'(bus.haddr) >= 64'(DEPTH) * 64'd4);
      case (bus.hsize)
         3'd0:    ;
         3'd1:    if (bus.haddr[0])     addr_err = 1'b1;
         3'd2:    if (|bus.haddr[1:0])  addr_err = 1'b1;
         default: addr_err = 1'b1;
      endcase
   end
`else
   assign addr_err = 1'b0;
`endif

   // Address bits above the array index are only inspected by the error check.
   assign unused_bits = ^{bus.htrans[0], bus.haddr[31:AW+2]};

   // The data phase completes in the first ready cycle after acceptance.
   assign complete = (state_q == ST_IDLE) && dp_valid_q;
   assign wr_fire  = complete && write_q;
   assign rd_fire  = complete && !write_q;

   // Little-endian lanes; alignment bits below the transfer size are ignored.
   // NOTE: every always_comb output gets a value on every path (here via the
   // default arm) so no latch is inferred.
   always_comb begin
      case (size_q)
         3'd0:    lanes = 4'b0001 << offs_q;
         3'd1:    lanes = offs_q[1] ? 4'b1100 : 4'b0011;
         default: lanes = 4'b1111;
      endcase
   end

   // Reading the array with the registered address in the completing cycle
   // sees any write committed on the preceding edge, so a read right after a
   // write to the same word returns the new data without forwarding logic.
   assign rd_word = mem[addr_q];

   // NOTE: state registers use non-blocking assignments only, so every
   // always_ff samples the pre-edge values regardless of evaluation order.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q    <= ST_IDLE;
         dp_valid_q <= 1'b0;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         offs_q     <= '0;
         write_q    <= 1'b0;
         size_q     <= '0;
         hrdata_q   <= '0;
      end else begin
         if (rd_fire) hrdata_q <= rd_word;

         case (state_q)
            ST_WAIT: begin
               if (wait_cnt_q == WS_LAST) begin
                  state_q    <= ST_IDLE;
                  wait_cnt_q <= '0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 3'd1;
               end
            end
            ST_ERR1: state_q <= ST_ERR2;
            default: begin   // ST_IDLE, ST_ERR2: ready for a new address phase
               if (accept && addr_err) begin
                  state_q    <= ST_ERR1;
                  dp_valid_q <= 1'b0;
               end else if (accept) begin
                  state_q    <= (WAIT_STATES > 0) ? ST_WAIT : ST_IDLE;
                  dp_valid_q <= 1'b1;
                  wait_cnt_q <= '0;
                  addr_q     <= bus.haddr[AW+1:2];
                  offs_q     <= bus.haddr[1:0];
                  write_q    <= bus.hwrite;
                  size_q     <= bus.hsize;
               end else begin
                  state_q    <= ST_IDLE;
                  dp_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   // NOTE: the array is deliberately left out of reset; it maps onto SRAM
   // macros and its contents are undefined until written. A reset mid-transfer
   // clears dp_valid_q asynchronously, so the aborted write never fires.
   always_ff @(posedge hclk) begin
      if (wr_fire) begin
         for (int b = 0; b < 4; b++) begin
            if (lanes[b]) mem[addr_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
         end
      end
   end

   assign bus.hreadyout = (state_q == ST_IDLE) || (state_q == ST_ERR2);
   assign bus.hrdata    = rd_fire ? rd_word : hrdata_q;

`ifdef AHB_SRAM_ERR_EN
   assign bus.hresp = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
   assign bus.hresp = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_ahb_sram_slave
// Two instances share the address/control/data stimulus: dut1 has one wait
// state, dut0 has none; each has its own select and reset. A transfer-level
// model (word array + per-transfer latency) sets the expected response of
// both slaves for every cycle, and one negedge process compares them.
// -----------------------------------------------------------------------------
module tb_ahb_sram_slave;
   localparam int DEPTH = 256;
`ifdef AHB_SRAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } op_t;

   logic        clk = 1'b0;
   logic        rst0_n, rst1_n;
   logic        hsel0, hsel1;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;

   ahb_sram_slave_if bus0 ();
   ahb_sram_slave_if bus1 ();

   assign bus0.hsel   = hsel0;
   assign bus1.hsel   = hsel1;
   assign bus0.haddr  = haddr;
   assign bus1.haddr  = haddr;
   assign bus0.htrans = htrans;
   assign bus1.htrans = htrans;
   assign bus0.hwrite = hwrite;
   assign bus1.hwrite = hwrite;
   assign bus0.hsize  = hsize;
   assign bus1.hsize  = hsize;
   assign bus0.hwdata = hwdata;
   assign bus1.hwdata = hwdata;
   assign bus0.hready = bus0.hreadyout;   // single slave on each bus
   assign bus1.hready = bus1.hreadyout;

   ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
      .hclk(clk), .hresetn(rst0_n), .bus(bus0)
   );
   ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(1)) dut1 (
      .hclk(clk), .hresetn(rst1_n), .bus(bus1)
   );

   always #5 clk = ~clk;

   // ---------------- model state and scoreboard counters ----------------
   logic [31:0] mdl [2][DEPTH];
   logic        exp_rdy  [2];
   logic        exp_resp [2];
   logic [31:0] last_rd  [2];
   int          low_cnt  [2];
   int          resp_cnt [2];
   int          n_cmp = 0;
   int          n_bad = 0;
   op_t         ops [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Single compare process: both slaves, every cycle.
   always @(negedge clk) begin
      check("dut0_hreadyout", bus0.hreadyout, exp_rdy[0]);
      check("dut0_hresp",     bus0.hresp,     exp_resp[0]);
      check("dut0_hrdata",    bus0.hrdata,    last_rd[0]);
      check("dut1_hreadyout", bus1.hreadyout, exp_rdy[1]);
      check("dut1_hresp",     bus1.hresp,     exp_resp[1]);
      check("dut1_hrdata",    bus1.hrdata,    last_rd[1]);
      if (bus0.hreadyout === 1'b0) low_cnt[0]++;
      if (bus1.hreadyout === 1'b0) low_cnt[1]++;
      if (bus0.hresp === 1'b1)     resp_cnt[0]++;
      if (bus1.hresp === 1'b1)     resp_cnt[1]++;
   end

   // ---------------- transfer-level model ----------------
   function automatic int nbytes(input logic [2:0] s);
      return (s > 3'd2) ? 4 : (1 << s);
   endfunction

   function automatic bit is_err(input op_t o);
      return ERR_EN && ((o.addr >= 32'(DEPTH * 4)) || (o.size > 3'd2) ||
                        ((o.addr % nbytes(o.size)) != 0));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic mdl_write(input int d, input op_t o);
      int          n;
      int          base;
      logic [31:0] w;
      n    = nbytes(o.size);
      base = int'(o.addr[1:0]) & ~(n - 1);
      w    = mdl[d][widx(o.addr)];
      for (int b = base; b < base + n; b++) w[8*b +: 8] = o.wdata[8*b +: 8];
      mdl[d][widx(o.addr)] = w;
   endtask

   // ---------------- drivers ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         exp_rdy[d]  = 1'b1;
         exp_resp[d] = 1'b0;
      end
      hsel0  = 1'b0;
      hsel1  = 1'b0;
      htrans = 2'b00;
   endtask

   task automatic drive_addr(input int d, input op_t o);
      if (d == 0) hsel0 = 1'b1;
      else        hsel1 = 1'b1;
      htrans = 2'b10;
      haddr  = o.addr;
      hwrite = o.wr;
      hsize  = o.size;
   endtask

   task automatic add(input bit wr, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] wd);
      op_t o;
      o.wr = wr; o.addr = a; o.size = s; o.wdata = wd;
      ops.push_back(o);
   endtask

   // Back-to-back run of the queued transfers on slave d: the next address
   // phase is presented during every data-phase cycle of the current one.
   task automatic run_ops(input int d);
      int ws;
      int nw;
      bit err;
      ws = (d == 1) ? 1 : 0;
      next_cycle();
      drive_addr(d, ops[0]);
      for (int k = 0; k < ops.size(); k++) begin
         err = is_err(ops[k]);
         nw  = err ? 1 : ws;
         for (int w = 0; w <= nw; w++) begin
            next_cycle();
            if (k + 1 < ops.size()) drive_addr(d, ops[k+1]);
            hwdata      = ops[k].wdata;
            exp_rdy[d]  = (w == nw);
            exp_resp[d] = err;
            if (w == nw && !err && !ops[k].wr) last_rd[d] = mdl[d][widx(ops[k].addr)];
         end
         if (!err && ops[k].wr) mdl_write(d, ops[k]);
      end
      next_cycle();
      ops.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int l;
      int r;
      rst0_n = 1'b0; rst1_n = 1'b0;
      hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; htrans = 2'b00;
      hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
      for (int d = 0; d < 2; d++) begin
         exp_rdy[d] = 1'b1; exp_resp[d] = 1'b0; last_rd[d] = '0;
         low_cnt[d] = 0; resp_cnt[d] = 0;
      end
      repeat (3) @(posedge clk);
      #3;
      rst0_n = 1'b1; rst1_n = 1'b1;

      // One wait state: word write then read of 0x10.
      add(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
      add(1'b0, 32'h10, 3'd2, 32'h0);
      l = low_cnt[1];
      run_ops(1);
      check("ws1_read_0x10", bus1.hrdata, 32'hDEADBEEF);
      check("ws1_low_cycles", 32'(low_cnt[1] - l), 32'd2);

      // Byte write into lane 3, then halfword into the upper half.
      add(1'b1, 32'h10, 3'd2, 32'h11223344);
      add(1'b1, 32'h13, 3'd0, 32'hAAAAAAAA);
      add(1'b0, 32'h10, 3'd2, 32'h0);
      run_ops(1);
      check("byte_lane3", bus1.hrdata, 32'hAA223344);
      add(1'b1, 32'h12, 3'd1, 32'h77665566);
      add(1'b0, 32'h10, 3'd2, 32'h0);
      run_ops(1);
      check("half_upper", bus1.hrdata, 32'h77663344);

      // Deselected NONSEQ write and a selected BUSY write: no array access.
      next_cycle();
      htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2; hwdata = 32'hFFFFFFFF;
      next_cycle();
      hsel1 = 1'b1; htrans = 2'b01;
      next_cycle();
      add(1'b0, 32'h10, 3'd2, 32'h0);
      run_ops(1);
      check("no_access_idle", bus1.hrdata, 32'h77663344);

      // Out-of-range read and an oversize write.
      add(1'b1, 32'h0, 3'd2, 32'hCAFEF00D);
      add(1'b0, 32'h400, 3'd2, 32'h0);
      r = resp_cnt[1];
      run_ops(1);
      if (ERR_EN) check("err_resp_cycles", 32'(resp_cnt[1] - r), 32'd2);
      else        check("wrap_read_0x400", bus1.hrdata, 32'hCAFEF00D);
      add(1'b1, 32'h30, 3'd2, 32'h01020304);
      add(1'b1, 32'h30, 3'd3, 32'hA5A5A5A5);
      add(1'b0, 32'h30, 3'd2, 32'h0);
      run_ops(1);
      check("size3_write", bus1.hrdata, ERR_EN ? 32'h01020304 : 32'hA5A5A5A5);

      // Reset during the wait state of a write to 0x20.
      add(1'b1, 32'h20, 3'd2, 32'h55AA55AA);
      run_ops(1);
      next_cycle();
      hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
      next_cycle();
      hwdata = 32'h12345678;
      exp_rdy[1] = 1'b0;
      @(negedge clk);
      #1;
      rst1_n = 1'b0;
      last_rd[1] = '0;
      exp_rdy[1] = 1'b1;
      #1;
      check("rst_hreadyout", bus1.hreadyout, 32'd1);
      check("rst_hresp",     bus1.hresp,     32'd0);
      check("rst_hrdata",    bus1.hrdata,    32'd0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst1_n = 1'b1;
      add(1'b0, 32'h20, 3'd2, 32'h0);
      run_ops(1);
      check("abort_keeps_0x20", bus1.hrdata, 32'h55AA55AA);

      // Zero wait states: back-to-back writes then reads.
      add(1'b1, 32'h0, 3'd2, 32'h00000011);
      add(1'b1, 32'h4, 3'd2, 32'h00000022);
      add(1'b0, 32'h0, 3'd2, 32'h0);
      add(1'b0, 32'h4, 3'd2, 32'h0);
      l = low_cnt[0];
      run_ops(0);
      check("ws0_read_0x4", bus0.hrdata, 32'h00000022);
      add(1'b1, 32'h8, 3'd2, 32'h89ABCDEF);
      add(1'b0, 32'h8, 3'd2, 32'h0);
      run_ops(0);
      check("ws0_raw_0x8", bus0.hrdata, 32'h89ABCDEF);
      check("ws0_no_wait", 32'(low_cnt[0] - l), 32'd0);

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
      $fatal(1, "watchdog expired");
   end

endmodule
